rr_mux_arb: RTL



---
 rtl/rr_mux_arb.sv | 97 +++++++++
 1 files changed

// File: rtl/rr_mux_arb.sv
// N-channel valid/ready multiplexer with round-robin or fixed-select arbitration
// and a one-entry registered output stage that sustains one word per clock.
module rr_mux_arb #(
    parameter int CH = 4,
    parameter int W  = 8,
    localparam int SW = (CH > 2) ? $clog2(CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CH*W-1:0]   in_data,
    input  logic [CH-1:0]     in_valid,
    output logic [CH-1:0]     in_ready,
    input  logic              mode,
    input  logic [SW-1:0]     sel,
    output logic [W-1:0]      out_data,
    output logic [SW-1:0]     out_ch,
    output logic              out_valid,
    input  logic              out_ready
);

    logic [SW-1:0] ptr;
    logic [CH-1:0] grant;
    logic          any_grant;
    logic [SW-1:0] grant_idx;
    logic [W-1:0]  grant_data;
    logic          ld;
    logic [W-1:0]  ch_data [CH];

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_unpack
            assign ch_data[gi] = in_data[gi*W +: W];
        end
    endgenerate

    // The output register can take a new word whenever it is empty or being drained.
    assign ld = ~out_valid | out_ready;

    always_comb begin
        grant      = '0;
        any_grant  = 1'b0;
        grant_idx  = '0;
        grant_data = '0;
        if (!mode) begin
            // Cyclic search: first the channels at or above ptr, then those below it.
            for (int i = 0; i < CH; i++) begin
                if (!any_grant && in_valid[i] && (SW'(i) >= ptr)) begin
                    grant[i]   = 1'b1;
                    any_grant  = 1'b1;
                    grant_idx  = SW'(i);
                    grant_data = ch_data[i];
                end
            end
            for (int i = 0; i < CH; i++) begin
                if (!any_grant && in_valid[i] && (SW'(i) < ptr)) begin
                    grant[i]   = 1'b1;
                    any_grant  = 1'b1;
                    grant_idx  = SW'(i);
                    grant_data = ch_data[i];
                end
            end
        end else begin
            // A select value beyond the last channel simply matches nothing.
            for (int i = 0; i < CH; i++) begin
                if (sel == SW'(i) && in_valid[i]) begin
                    grant[i]   = 1'b1;
                    any_grant  = 1'b1;
                    grant_idx  = SW'(i);
                    grant_data = ch_data[i];
                end
            end
        end
    end

    // Held low while in reset so no producer sees a handshake that cannot complete.
    assign in_ready = (ld && rst_n) ? grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (ld) begin
            if (any_grant) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_ch    <= grant_idx;
                if (!mode) begin
                    ptr <= (grant_idx == SW'(CH - 1)) ? '0 : grant_idx + SW'(1);
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
